// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin writeback arbiter driving the shared result bus (CDB)
module wb_arbiter #(
  parameter int DATA     = 32,
  parameter int NUM_UNIT = 4,
  parameter int RD_W     = 7,
  parameter int EXP_W    = 4
) (
  input  logic                               clk,
  input  logic                               reset_,
  input  logic                               flush_,
  input  logic [NUM_UNIT-1:0]                wb_req_,
  input  logic [NUM_UNIT-1:0][RD_W-1:0]      pre_wb_rd,
  output logic [NUM_UNIT-1:0]                wb_ack_,
  input  logic [NUM_UNIT-1:0]                unit_wb_e_,
  input  logic [NUM_UNIT-1:0][RD_W-1:0]      unit_wb_rd,
  input  logic [NUM_UNIT-1:0][DATA-1:0]      unit_wb_data,
  input  logic [NUM_UNIT-1:0]                unit_wb_exp_,
  input  logic [NUM_UNIT-1:0][EXP_W-1:0]     unit_wb_exp_code,
  input  logic [NUM_UNIT-1:0]                unit_wb_pred_miss_,
  input  logic [NUM_UNIT-1:0]                unit_wb_jump_miss_,
  output logic                               cdb_pre_e_,
  output logic [RD_W-1:0]                    cdb_pre_rd,
  output logic                               cdb_e_,
  output logic [RD_W-1:0]                    cdb_rd,
  output logic [DATA-1:0]                    cdb_data,
  output logic                               cdb_exp_,
  output logic [EXP_W-1:0]                   cdb_exp_code,
  output logic                               cdb_pred_miss_,
  output logic                               cdb_jump_miss_,
  output logic                               proto_err
);

  localparam int              UNIT = (NUM_UNIT > 1) ? $clog2(NUM_UNIT) : 1;
  localparam logic [UNIT:0]   NU   = (UNIT+1)'(NUM_UNIT);
  localparam logic [UNIT-1:0] LAST = UNIT'(NUM_UNIT - 1);

  logic [UNIT-1:0]  ptr_q, ptr_d;
  logic             gnt_v_q, gnt_v_d;
  logic [UNIT-1:0]  gnt_u_q, gnt_u_d;
  logic             cdb_e_q, cdb_e_d;
  logic [RD_W-1:0]  rd_q, rd_d;
  logic [DATA-1:0]  data_q, data_d;
  logic             exp_q, exp_d;
  logic [EXP_W-1:0] code_q, code_d;
  logic             pm_q, pm_d;
  logic             jm_q, jm_d;
  logic             perr_q, perr_d;

  logic            found, grant, res_ok, stray, missing;
  logic [UNIT-1:0] g;
  logic [UNIT:0]   sum;

  // Search upward from the pointer, wrapping modulo NUM_UNIT.
  always_comb begin
    found = 1'b0;
    g     = '0;
    sum   = '0;
    for (int i = 0; i < NUM_UNIT; i++) begin
      sum = {1'b0, ptr_q} + (UNIT+1)'(i);
      if (sum >= NU) sum = sum - NU;
      if (!found && !wb_req_[sum[UNIT-1:0]]) begin
        found = 1'b1;
        g     = sum[UNIT-1:0];
      end
    end
  end

  // Reset is folded in so the ack stays released while reset_ is low.
  assign grant = found & flush_ & reset_;

  always_comb begin
    wb_ack_ = '1;
    if (grant) wb_ack_[g] = 1'b0;
  end

  assign cdb_pre_e_ = ~grant;
  assign cdb_pre_rd = grant ? pre_wb_rd[g] : '0;

  always_comb begin
    res_ok  = gnt_v_q & ~unit_wb_e_[gnt_u_q] & flush_;
    missing = gnt_v_q & unit_wb_e_[gnt_u_q];
    stray   = 1'b0;
    for (int i = 0; i < NUM_UNIT; i++) begin
      if (!unit_wb_e_[i] && !(gnt_v_q && gnt_u_q == UNIT'(i))) stray = 1'b1;
    end
    // A flush cycle drops whatever result is on the unit side without complaint.
    perr_d  = perr_q | (flush_ & (stray | missing));

    ptr_d   = ptr_q;
    if (grant) ptr_d = (g == LAST) ? '0 : g + UNIT'(1);
    gnt_v_d = grant;
    gnt_u_d = grant ? g : gnt_u_q;

    cdb_e_d = ~res_ok;
    rd_d    = rd_q;
    data_d  = data_q;
    exp_d   = exp_q;
    code_d  = code_q;
    pm_d    = pm_q;
    jm_d    = jm_q;
    if (res_ok) begin
      rd_d   = unit_wb_rd[gnt_u_q];
      data_d = unit_wb_data[gnt_u_q];
      exp_d  = unit_wb_exp_[gnt_u_q];
      code_d = unit_wb_exp_code[gnt_u_q];
      pm_d   = unit_wb_pred_miss_[gnt_u_q];
      jm_d   = unit_wb_jump_miss_[gnt_u_q];
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      ptr_q   <= '0;
      gnt_v_q <= 1'b0;
      gnt_u_q <= '0;
      cdb_e_q <= 1'b1;
      rd_q    <= '0;
      data_q  <= '0;
      exp_q   <= 1'b1;
      code_q  <= '0;
      pm_q    <= 1'b1;
      jm_q    <= 1'b1;
      perr_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      gnt_v_q <= gnt_v_d;
      gnt_u_q <= gnt_u_d;
      cdb_e_q <= cdb_e_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      exp_q   <= exp_d;
      code_q  <= code_d;
      pm_q    <= pm_d;
      jm_q    <= jm_d;
      perr_q  <= perr_d;
    end
  end

  assign cdb_e_         = cdb_e_q;
  assign cdb_rd         = rd_q;
  assign cdb_data       = data_q;
  assign cdb_exp_       = exp_q;
  assign cdb_exp_code   = code_q;
  assign cdb_pred_miss_ = pm_q;
  assign cdb_jump_miss_ = jm_q;
  assign proto_err      = perr_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - randomized self-checking bench for wb_arbiter against a cycle reference model
module tb_wb_arbiter;

  logic             clk = 1'b0;
  logic             reset_;
  logic             flush_;
  logic [3:0]       wb_req_;
  logic [3:0][6:0]  pre_wb_rd;
  logic [3:0]       wb_ack_;
  logic [3:0]       unit_wb_e_;
  logic [3:0][6:0]  unit_wb_rd;
  logic [3:0][31:0] unit_wb_data;
  logic [3:0]       unit_wb_exp_;
  logic [3:0][3:0]  unit_wb_exp_code;
  logic [3:0]       unit_wb_pred_miss_;
  logic [3:0]       unit_wb_jump_miss_;
  logic             cdb_pre_e_;
  logic [6:0]       cdb_pre_rd;
  logic             cdb_e_;
  logic [6:0]       cdb_rd;
  logic [31:0]      cdb_data;
  logic             cdb_exp_;
  logic [3:0]       cdb_exp_code;
  logic             cdb_pred_miss_;
  logic             cdb_jump_miss_;
  logic             proto_err;

  wb_arbiter dut (
    .clk(clk), .reset_(reset_), .flush_(flush_), .wb_req_(wb_req_), .pre_wb_rd(pre_wb_rd),
    .wb_ack_(wb_ack_), .unit_wb_e_(unit_wb_e_), .unit_wb_rd(unit_wb_rd),
    .unit_wb_data(unit_wb_data), .unit_wb_exp_(unit_wb_exp_), .unit_wb_exp_code(unit_wb_exp_code),
    .unit_wb_pred_miss_(unit_wb_pred_miss_), .unit_wb_jump_miss_(unit_wb_jump_miss_),
    .cdb_pre_e_(cdb_pre_e_), .cdb_pre_rd(cdb_pre_rd), .cdb_e_(cdb_e_), .cdb_rd(cdb_rd),
    .cdb_data(cdb_data), .cdb_exp_(cdb_exp_), .cdb_exp_code(cdb_exp_code),
    .cdb_pred_miss_(cdb_pred_miss_), .cdb_jump_miss_(cdb_jump_miss_), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int          m_ptr, m_gu;
  bit          m_gv, m_perr;
  logic        m_cdb_e, m_exp, m_pm, m_jm;
  logic [6:0]  m_rd;
  logic [31:0] m_data;
  logic [3:0]  m_code;

  // unit-side behaviour knobs
  logic [3:0]  keep;
  bit          auto_res;
  logic [31:0] res_data [4];
  logic        res_exp_n [4];
  logic [3:0]  res_code [4];
  logic        res_pm [4];
  logic        res_jm [4];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr(input int p, input logic [3:0] req_n);
    for (int k = 0; k < 4; k++)
      if (!req_n[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_gu = 0; m_gv = 0; m_perr = 0;
    m_cdb_e = 1; m_exp = 1; m_pm = 1; m_jm = 1; m_rd = '0; m_data = '0; m_code = '0;
  endtask

  // Called at a falling edge once inputs are set; checks just before the rising edge.
  task automatic step(input int dly = 4);
    int g;
    logic [3:0] ea;
    bit ok;
    #dly;
    g  = flush_ ? rr(m_ptr, wb_req_) : -1;
    ea = 4'hF;
    if (g >= 0) ea[g] = 1'b0;
    check_eq("wb_ack_", wb_ack_, ea);
    check_eq("cdb_pre_e_", cdb_pre_e_, (g < 0));
    if (g >= 0) check_eq("cdb_pre_rd", cdb_pre_rd, pre_wb_rd[g]);
    check_eq("cdb_e_", cdb_e_, m_cdb_e);
    if (!m_cdb_e) begin
      check_eq("cdb_rd", cdb_rd, m_rd);
      check_eq("cdb_data", cdb_data, m_data);
      check_eq("cdb_exp_", cdb_exp_, m_exp);
      check_eq("cdb_exp_code", cdb_exp_code, m_code);
      check_eq("cdb_pred_miss_", cdb_pred_miss_, m_pm);
      check_eq("cdb_jump_miss_", cdb_jump_miss_, m_jm);
    end
    check_eq("proto_err", proto_err, m_perr);

    ok = m_gv && flush_ && !unit_wb_e_[m_gu];
    if (flush_) begin
      for (int u = 0; u < 4; u++)
        if (!unit_wb_e_[u] && !(m_gv && u == m_gu)) m_perr = 1;
      if (m_gv && unit_wb_e_[m_gu]) m_perr = 1;
    end
    m_cdb_e = !ok;
    if (ok) begin
      m_rd = unit_wb_rd[m_gu]; m_data = unit_wb_data[m_gu]; m_exp = unit_wb_exp_[m_gu];
      m_code = unit_wb_exp_code[m_gu]; m_pm = unit_wb_pred_miss_[m_gu]; m_jm = unit_wb_jump_miss_[m_gu];
    end
    if (g >= 0) m_ptr = (g + 1) % 4;
    m_gv = (g >= 0);
    if (g >= 0) m_gu = g;

    @(negedge clk);
    if (g >= 0 && !keep[g]) wb_req_[g] = 1'b1;
    for (int u = 0; u < 4; u++) begin
      unit_wb_data[u] = $urandom;
      unit_wb_rd[u] = 7'($urandom);
      unit_wb_exp_code[u] = 4'($urandom);
    end
    unit_wb_e_ = '1; unit_wb_exp_ = '1; unit_wb_pred_miss_ = '1; unit_wb_jump_miss_ = '1;
    if (m_gv && auto_res) begin
      unit_wb_e_[m_gu]         = 1'b0;
      unit_wb_data[m_gu]       = res_data[m_gu];
      unit_wb_rd[m_gu]         = pre_wb_rd[m_gu];
      unit_wb_exp_[m_gu]       = res_exp_n[m_gu];
      unit_wb_exp_code[m_gu]   = res_code[m_gu];
      unit_wb_pred_miss_[m_gu] = res_pm[m_gu];
      unit_wb_jump_miss_[m_gu] = res_jm[m_gu];
    end
    flush_ = 1'b1;
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    wb_req_ = '1; unit_wb_e_ = '1; flush_ = 1'b1;
    unit_wb_exp_ = '1; unit_wb_pred_miss_ = '1; unit_wb_jump_miss_ = '1;
    keep = '0; auto_res = 1;
    model_reset();
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
  endtask

  initial begin
    pre_wb_rd = '0; unit_wb_rd = '0; unit_wb_data = '0; unit_wb_exp_code = '0;
    for (int u = 0; u < 4; u++) begin
      res_data[u] = 32'(u + 1); res_exp_n[u] = 1; res_code[u] = '0; res_pm[u] = 1; res_jm[u] = 1;
    end
    do_reset();
    check_eq("rst_ack", wb_ack_, 4'hF);
    check_eq("rst_cdb_e", cdb_e_, 1'b1);
    check_eq("rst_pre_e", cdb_pre_e_, 1'b1);
    check_eq("rst_data", cdb_data, 32'h0);
    check_eq("rst_perr", proto_err, 1'b0);

    // single request, data 9
    pre_wb_rd[0] = 7'h42; res_data[0] = 32'd9; wb_req_[0] = 1'b0;
    #1 check_eq("t1_ack", wb_ack_, 4'b1110);
    step(3);
    step();
    check_eq("t1_cdb_e", cdb_e_, 1'b0);
    check_eq("t1_data", cdb_data, 32'd9);
    check_eq("t1_rd", cdb_rd, 7'h42);
    step(); step();

    // round-robin between units 0 and 2
    pre_wb_rd[2] = 7'h13; keep = 4'b0101; wb_req_[0] = 1'b0; wb_req_[2] = 1'b0;
    step(); step(); step();
    keep = '0;
    repeat (5) step();

    // wrap-around: drive pointer to 3, then units 1 and 3
    wb_req_[2] = 1'b0; step(); step();
    pre_wb_rd[1] = 7'h21; pre_wb_rd[3] = 7'h33; wb_req_[1] = 1'b0; wb_req_[3] = 1'b0;
    #1 check_eq("t3_first", wb_ack_, 4'b0111);
    step(3);
    step();
    wb_req_[0] = 1'b0; wb_req_[2] = 1'b0;
    #1 check_eq("t3_ptr2", wb_ack_, 4'b1011);
    step(3);
    repeat (4) step();

    // flush during result cycle
    wb_req_[1] = 1'b0; step();
    flush_ = 1'b0; step();
    wb_req_[0] = 1'b0; step();
    check_eq("t4_perr", proto_err, 1'b0);
    repeat (3) step();

    // stray result with nothing outstanding
    unit_wb_e_[2] = 1'b0; step();
    step(); step();
    check_eq("t5_sticky", proto_err, 1'b1);
    do_reset();
    check_eq("t5_cleared", proto_err, 1'b0);

    // exception passthrough, then reset mid-transfer
    res_exp_n[1] = 0; res_code[1] = 4'hA; res_pm[1] = 0; res_data[1] = 32'h1234;
    wb_req_[1] = 1'b0; step(); step();
    check_eq("t6_exp", cdb_exp_, 1'b0);
    check_eq("t6_code", cdb_exp_code, 4'hA);
    check_eq("t6_pm", cdb_pred_miss_, 1'b0);
    check_eq("t6_jm", cdb_jump_miss_, 1'b1);
    step();
    wb_req_[3] = 1'b0; step();
    wb_req_[0] = 1'b0;
    #2 reset_ = 1'b0;
    #1;
    check_eq("t6r_ack", wb_ack_, 4'hF);
    check_eq("t6r_pre_e", cdb_pre_e_, 1'b1);
    check_eq("t6r_cdb_e", cdb_e_, 1'b1);
    check_eq("t6r_data", cdb_data, 32'h0);
    check_eq("t6r_exp", cdb_exp_, 1'b1);
    check_eq("t6r_code", cdb_exp_code, 4'h0);
    check_eq("t6r_pm", cdb_pred_miss_, 1'b1);
    @(negedge clk);
    do_reset();

    // missing result
    auto_res = 0; wb_req_[3] = 1'b0;
    step(); step(); step();
    check_eq("miss_perr", proto_err, 1'b1);
    do_reset();

    // randomized traffic with flushes
    for (int c = 0; c < 400; c++) begin
      for (int u = 0; u < 4; u++) begin
        if (wb_req_[u] && $urandom_range(1) == 1) begin
          wb_req_[u] = 1'b0;
          pre_wb_rd[u] = 7'($urandom);
        end
        res_data[u] = $urandom; res_exp_n[u] = 1'($urandom); res_code[u] = 4'($urandom);
        res_pm[u] = 1'($urandom); res_jm[u] = 1'($urandom);
      end
      flush_ = ($urandom_range(11) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Responder end of the execution-unit writeback handshake (wb_req_/wb_ack_/wb_e_).
- Collects writeback requests from NUM_UNIT execution units (ALU, MUL/DIV, LSU, ...) and grants one unit per cycle using round-robin.
- Drives the shared result bus (CDB) consumed by the ROB, register file and reservation stations.
- Issues an early wakeup notification in the grant cycle and a registered full result two cycles after the request.

Parameters:
- DATA, `DataWidth, result data width
- NUM_UNIT, 4, number of requesting execution units (>=2)
- UNIT, $clog2(NUM_UNIT), grant pointer width (derived, not overridable)

Ports:
- clk  in  1  clock
- reset_  in  1  asynchronous active-low reset
- flush_  in  1  active-low pipeline flush
- wb_req_  in  NUM_UNIT  per-unit writeback request, active-low
- pre_wb_rd  in  NUM_UNIT x RegFile_t  per-unit destination, valid with wb_req_
- wb_ack_  out  NUM_UNIT  one-hot-low grant
- unit_wb_e_  in  NUM_UNIT  per-unit result valid, active-low
- unit_wb_rd  in  NUM_UNIT x RegFile_t  per-unit result destination
- unit_wb_data  in  NUM_UNIT x DATA  per-unit result
- unit_wb_exp_  in  NUM_UNIT  exception flag, active-low
- unit_wb_exp_code  in  NUM_UNIT x ExpCode_t  exception code
- unit_wb_pred_miss_  in  NUM_UNIT  branch mispredict, active-low
- unit_wb_jump_miss_  in  NUM_UNIT  jump target miss, active-low
- cdb_pre_e_  out  1  early wakeup valid, active-low
- cdb_pre_rd  out  RegFile_t  early wakeup destination
- cdb_e_  out  1  result bus valid, active-low
- cdb_rd  out  RegFile_t  result destination
- cdb_data  out  DATA  result data
- cdb_exp_  out  1  exception flag
- cdb_exp_code  out  ExpCode_t  exception code
- cdb_pred_miss_  out  1  mispredict flag
- cdb_jump_miss_  out  1  jump miss flag
- proto_err  out  1  sticky protocol violation, active-high

Behaviour:
- Reset (async, reset_ low):
  - wb_ack_ all ones.
  - cdb_pre_e_, cdb_e_, cdb_exp_, cdb_pred_miss_, cdb_jump_miss_ high.
  - cdb_rd, cdb_pre_rd, cdb_data, cdb_exp_code zero.
  - Round-robin pointer 0; grant register idle; proto_err 0.
- Arbitration, cycle N (combinational on wb_req_ and pointer):
  - Grant the first requesting unit found searching from pointer upward, wrapping modulo NUM_UNIT.
  - At most one wb_ack_ bit is low.
  - cdb_pre_e_ is low and cdb_pre_rd = pre_wb_rd[g] in the same cycle.
  - No request: no ack, cdb_pre_e_ high.
- Pointer: on a grant, the pointer becomes (g+1) mod NUM_UNIT at the next edge; otherwise it holds.
- A request not acked stays asserted; the unit holds pre_wb_rd stable until acked.
- Grant register: records valid and g at the edge ending cycle N.
- Cycle N+1:
  - The granted unit drives unit_wb_e_[g] low with its result.
  - The arbiter muxes unit g's fields and registers them.
- Cycle N+2: cdb_e_ low with the registered fields, for exactly one cycle.
- Throughput: back-to-back grants are allowed, one per cycle; cdb_e_ can be low every cycle.
- Missing result: if the granted unit does not assert unit_wb_e_ in N+1, cdb_e_ stays high in N+2 and proto_err is set.
- Unexpected result: unit_wb_e_ low from any non-granted unit, or with no grant outstanding, sets proto_err. That result is ignored.
- proto_err stays set until reset.
- Flush (flush_ low in a cycle):
  - No ack is issued and cdb_pre_e_ is high.
  - The grant register is cleared, so a result arriving in the following cycle is dropped without error.
  - cdb_e_ is forced high at the next edge.
  - Pointer holds.
- Flush and grant in the same cycle: flush wins.
- Result bus field widths pass through unchanged; no arithmetic is performed on data.

Test Plan:
1. Single request: unit 0 requests with rd={TYPE_ROB,2} in cycle N; unit drives data 9 in N+1 -> wb_ack_=4'b1110 and cdb_pre_rd addr 2 in N; cdb_e_ low with cdb_data=9 and cdb_rd addr 2 in N+2 only.
2. Round-robin: units 0 and 2 request continuously from pointer 0 -> grants 0, 2, 0, 2 on consecutive cycles; cdb_e_ low four consecutive cycles; the loser's request is held without ack.
3. Wrap-around: pointer=3, units 1 and 3 requesting -> grant 3, then grant 1, pointer ends at 2.
4. Flush: unit 1 acked in N, flush_ low in N+1 while unit 1 drives its result -> cdb_e_ stays high in N+2; proto_err remains 0; a new request in N+2 is granted normally.
5. Protocol violation: unit 2 drives unit_wb_e_ low with no grant outstanding -> proto_err=1 next cycle and stays set; cdb_e_ stays high; reset clears proto_err.
6. Exception passthrough: granted unit returns exp_=low with a nonzero code and pred_miss_=low -> cdb_exp_ and cdb_pred_miss_ low with the matching code in N+2; reset asserted mid-transfer clears all outputs immediately.
